// File: rtl/l1_instr_refill_ctrl.sv
// Fetch sequencer for the 2-way L1 instruction cache: lookup, L2 refill handshake
// (primary or next-line block), fill strobes, replay, and saturating hit/miss stats.
module l1_instr_refill_ctrl #(
    parameter int unsigned tag_size    = 9,
    parameter int unsigned idx_size    = 6,
    parameter int unsigned word_size   = 2,
    parameter int unsigned offset_size = 1,
    parameter int unsigned cnt_width   = 16
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                fetch_req_i,
    input  logic [tag_size+idx_size+word_size+offset_size-1:0]  fetch_addr_i,
    output logic                                                fetch_valid_o,
    output logic [31:0]                                         fetch_data_o,
    output logic                                                fetch_busy_o,
    output logic                                                cache_read_o,
    output logic                                                cache_instr_write_start_o,
    output logic                                                cache_write_o,
    output logic                                                cache_write_next_o,
    output logic [tag_size+idx_size+word_size+offset_size-1:0]  cache_addr_o,
    input  logic                                                cache_hit_i,
    input  logic                                                cache_miss_next_i,
    input  logic [31:0]                                         cache_data_i,
    output logic                                                l2_req_o,
    output logic [tag_size+idx_size-1:0]                        l2_addr_o,
    input  logic                                                l2_ack_i,
    output logic [cnt_width-1:0]                                hit_cnt_o,
    output logic [cnt_width-1:0]                                miss_cnt_o
);

    localparam int unsigned addr_w = tag_size + idx_size + word_size + offset_size;
    localparam int unsigned blk_w  = tag_size + idx_size;
    localparam int unsigned low_w  = word_size + offset_size;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_START,
        S_WRITE
    } state_e;

    state_e                 state_q,    state_d;
    logic [addr_w-1:0]      addr_q,     addr_d;
    logic [blk_w-1:0]       fill_blk_q, fill_blk_d;
    logic                   next_q,     next_d;
    logic                   first_q,    first_d;
    logic [cnt_width-1:0]   hit_cnt_q,  hit_cnt_d;
    logic [cnt_width-1:0]   miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            fill_blk_q <= '0;
            next_q     <= 1'b0;
            first_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fill_blk_q <= fill_blk_d;
            next_q     <= next_d;
            first_q    <= first_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state and strobe decode; the cache answers a LOOKUP in the same cycle.
    always_comb begin
        state_d                   = state_q;
        addr_d                    = addr_q;
        fill_blk_d                = fill_blk_q;
        next_d                    = next_q;
        first_d                   = first_q;
        hit_cnt_d                 = hit_cnt_q;
        miss_cnt_d                = miss_cnt_q;
        fetch_valid_o             = 1'b0;
        fetch_data_o              = '0;
        cache_read_o              = 1'b0;
        cache_instr_write_start_o = 1'b0;
        cache_write_o             = 1'b0;
        cache_write_next_o        = 1'b0;
        cache_addr_o              = addr_q;
        l2_req_o                  = 1'b0;
        l2_addr_o                 = '0;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_req_i) begin
                    addr_d  = fetch_addr_i;
                    first_d = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cache_read_o = 1'b1;
                if (cache_hit_i && !cache_miss_next_i) begin
                    fetch_valid_o = 1'b1;
                    fetch_data_o  = cache_data_i;
                    if (!first_q && (hit_cnt_q != {cnt_width{1'b1}})) begin
                        hit_cnt_d = hit_cnt_q + cnt_width'(1);
                    end
                    state_d = S_IDLE;
                end else begin
                    // Straddling compressed instruction needs the following block.
                    if (cache_hit_i) begin
                        fill_blk_d = addr_q[addr_w-1:low_w] + blk_w'(1);
                        next_d     = 1'b1;
                    end else begin
                        fill_blk_d = addr_q[addr_w-1:low_w];
                        next_d     = 1'b0;
                    end
                    first_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                l2_req_o  = 1'b1;
                l2_addr_o = fill_blk_q;
                if (l2_ack_i) begin
                    if (miss_cnt_q != {cnt_width{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + cnt_width'(1);
                    end
                    state_d = S_START;
                end
            end
            S_START: begin
                cache_instr_write_start_o = 1'b1;
                cache_addr_o              = {fill_blk_q, {low_w{1'b0}}};
                state_d                   = S_WRITE;
            end
            S_WRITE: begin
                cache_write_o      = 1'b1;
                cache_write_next_o = next_q;
                cache_addr_o       = {fill_blk_q, {low_w{1'b0}}};
                state_d            = S_LOOKUP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_busy_o = (state_q != S_IDLE);
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
